// File: rtl/controle_jogo_param.sv
// Turn/phase controller for ultimate tic-tac-toe: macro pick, micro pick, validation, write, result check.
// Optional macro TURN_TIMEOUT_EN forfeits a move phase after TIMEOUT_CYCLES idle cycles.
module controle_jogo_param #(
  parameter int NUM_PLAYERS    = 2,
  parameter int PLAYER_W       = 1,
  parameter int VALID_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                tem_jogada,
  input  logic                macro_vencida,
  input  logic                micro_jogada,
  input  logic                fim_jogo,
  output logic                zeraR_macro,
  output logic                zeraR_micro,
  output logic                zeraEdge,
  output logic                registraR_macro,
  output logic                registraR_micro,
  output logic                sinal_macro,
  output logic                sinal_valida_macro,
  output logic                jogar_macro,
  output logic                jogar_micro,
  output logic                we_board,
  output logic                we_board_state,
  output logic                pronto,
  output logic [PLAYER_W-1:0] jogador,
  output logic                timeout,
  output logic [3:0]          db_estado
);

  typedef enum logic [3:0] {
    INICIAL            = 4'h0,
    PREPARACAO         = 4'h1,
    JOGA_MACRO         = 4'h2,
    REGISTRA_MACRO     = 4'h3,
    VALIDA_MACRO       = 4'h4,
    JOGA_MICRO         = 4'h5,
    REGISTRA_MICRO     = 4'h6,
    VALIDA_MICRO       = 4'h7,
    REGISTRA_JOGADA    = 4'h8,
    VERIFICA_MACRO     = 4'h9,
    REGISTRA_RESULTADO = 4'hA,
    VERIFICA_TABULEIRO = 4'hB,
    TROCAR_JOGADOR     = 4'hC,
    DECIDE_MACRO       = 4'hD,
    FIM                = 4'hF
  } estado_t;

  localparam logic [TIMER_W-1:0]  VAL_LAST    = TIMER_W'(VALID_CYCLES - 1);
  localparam logic [PLAYER_W-1:0] PLAYER_LAST = PLAYER_W'(NUM_PLAYERS - 1);

  estado_t               estado_q, estado_d;
  logic [TIMER_W-1:0]    val_q, val_d;
  logic [PLAYER_W-1:0]   jog_q, jog_d;
  logic                  val_fim;
  logic                  expira;

`ifdef TURN_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] turn_q, turn_d;
  logic               tout_q, tout_d;
  logic               em_joga;

  always_comb begin
    em_joga = (estado_q == JOGA_MACRO) || (estado_q == JOGA_MICRO);
    turn_d  = em_joga ? turn_q + 1'b1 : '0;
    expira  = em_joga && (turn_q == TO_LAST);
    // A key press on the expiry cycle wins, so only an unanswered expiry is flagged
    tout_d  = expira && !tem_jogada;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      turn_q <= '0;
      tout_q <= 1'b0;
    end else begin
      turn_q <= turn_d;
      tout_q <= tout_d;
    end
  end

  assign timeout = tout_q;
`else
  assign expira  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    val_fim = (val_q == VAL_LAST);
    val_d   = ((estado_q == VALIDA_MACRO) || (estado_q == VALIDA_MICRO)) ? val_q + 1'b1 : '0;
    jog_d   = jog_q;
    if (estado_q == INICIAL)
      jog_d = '0;
    else if (estado_q == TROCAR_JOGADOR)
      jog_d = (jog_q == PLAYER_LAST) ? '0 : jog_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      val_q    <= '0;
      jog_q    <= '0;
    end else begin
      estado_q <= estado_d;
      val_q    <= val_d;
      jog_q    <= jog_d;
    end
  end

  always_comb begin
    estado_d           = estado_q;
    zeraR_macro        = 1'b0;
    zeraR_micro        = 1'b0;
    zeraEdge           = 1'b0;
    registraR_macro    = 1'b0;
    registraR_micro    = 1'b0;
    sinal_macro        = 1'b0;
    sinal_valida_macro = 1'b0;
    jogar_macro        = 1'b0;
    jogar_micro        = 1'b0;
    we_board           = 1'b0;
    we_board_state     = 1'b0;
    pronto             = 1'b0;
    case (estado_q)
      INICIAL: begin
        zeraR_macro = 1'b1;
        zeraR_micro = 1'b1;
        zeraEdge    = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        zeraR_macro = 1'b1;
        zeraR_micro = 1'b1;
        estado_d    = JOGA_MACRO;
      end
      JOGA_MACRO: begin
        sinal_macro = 1'b1;
        jogar_macro = 1'b1;
        if (tem_jogada)  estado_d = REGISTRA_MACRO;
        else if (expira) estado_d = TROCAR_JOGADOR;
      end
      REGISTRA_MACRO: begin
        registraR_macro    = 1'b1;
        sinal_macro        = 1'b1;
        sinal_valida_macro = 1'b1;
        estado_d           = VALIDA_MACRO;
      end
      VALIDA_MACRO: begin
        sinal_valida_macro = 1'b1;
        if (val_fim) estado_d = macro_vencida ? PREPARACAO : JOGA_MICRO;
      end
      JOGA_MICRO: begin
        zeraR_micro = 1'b1;
        jogar_micro = 1'b1;
        if (tem_jogada)  estado_d = REGISTRA_MICRO;
        else if (expira) estado_d = TROCAR_JOGADOR;
      end
      REGISTRA_MICRO: begin
        registraR_micro = 1'b1;
        estado_d        = VALIDA_MICRO;
      end
      VALIDA_MICRO: begin
        if (val_fim) estado_d = micro_jogada ? JOGA_MICRO : REGISTRA_JOGADA;
      end
      REGISTRA_JOGADA: begin
        we_board = 1'b1;
        estado_d = VERIFICA_MACRO;
      end
      VERIFICA_MACRO:     estado_d = REGISTRA_RESULTADO;
      REGISTRA_RESULTADO: begin
        we_board_state = 1'b1;
        estado_d       = VERIFICA_TABULEIRO;
      end
      VERIFICA_TABULEIRO: estado_d = fim_jogo ? FIM : TROCAR_JOGADOR;
      TROCAR_JOGADOR:     estado_d = DECIDE_MACRO;
      DECIDE_MACRO: begin
        registraR_macro = 1'b1;
        estado_d        = macro_vencida ? PREPARACAO : JOGA_MICRO;
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_d = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign jogador   = jog_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_jogo_param.sv
// Directed bench for controle_jogo_param with NUM_PLAYERS=3, VALID_CYCLES=4, TIMEOUT_CYCLES=10.
module tb_controle_jogo_param;
  logic       clock = 1'b0;
  logic       reset, iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo;
  logic       zeraR_macro, zeraR_micro, zeraEdge, registraR_macro, registraR_micro;
  logic       sinal_macro, sinal_valida_macro, jogar_macro, jogar_micro;
  logic       we_board, we_board_state, pronto, timeout;
  logic [1:0] jogador;
  logic [3:0] db_estado;
  logic       exp_to;
  int         nchk = 0;
  int         nerr = 0;

  always #5 clock = ~clock;

  controle_jogo_param #(
    .NUM_PLAYERS(3), .PLAYER_W(2), .VALID_CYCLES(4), .TIMEOUT_CYCLES(10), .TIMER_W(16)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .macro_vencida(macro_vencida), .micro_jogada(micro_jogada), .fim_jogo(fim_jogo),
    .zeraR_macro(zeraR_macro), .zeraR_micro(zeraR_micro), .zeraEdge(zeraEdge),
    .registraR_macro(registraR_macro), .registraR_micro(registraR_micro),
    .sinal_macro(sinal_macro), .sinal_valida_macro(sinal_valida_macro),
    .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
    .we_board(we_board), .we_board_state(we_board_state), .pronto(pronto),
    .jogador(jogador), .timeout(timeout), .db_estado(db_estado)
  );

  // Expected Moore outputs per state:
  // {zeraR_macro, zeraR_micro, zeraEdge, registraR_macro, registraR_micro, sinal_macro,
  //  sinal_valida_macro, jogar_macro, jogar_micro, we_board, we_board_state, pronto}
  function automatic logic [11:0] exp_outs(input logic [3:0] s);
    case (s)
      4'h0:    return 12'b111000000000;
      4'h1:    return 12'b110000000000;
      4'h2:    return 12'b000001010000;
      4'h3:    return 12'b000101100000;
      4'h4:    return 12'b000000100000;
      4'h5:    return 12'b010000001000;
      4'h6:    return 12'b000010000000;
      4'h8:    return 12'b000000000100;
      4'hA:    return 12'b000000000010;
      4'hD:    return 12'b000100000000;
      4'hF:    return 12'b000000000001;
      default: return 12'b000000000000;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] s);
    chk({tag, "_estado"}, 32'(db_estado), 32'(s));
    chk({tag, "_outs"}, 32'({zeraR_macro, zeraR_micro, zeraEdge, registraR_macro,
                             registraR_micro, sinal_macro, sinal_valida_macro, jogar_macro,
                             jogar_micro, we_board, we_board_state, pronto}), 32'(exp_outs(s)));
    chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    cyc(); st("prep", 4'h1);
    iniciar = 1'b0;
  endtask

  // From preparacao through macro validation; macro_vencida pulses high except on the exit cycle
  task automatic macro_phase();
    cyc(); st("joga_macro", 4'h2);
    tem_jogada = 1'b1;
    cyc(); st("reg_macro", 4'h3);
    tem_jogada = 1'b0;
    macro_vencida = 1'b1;
    cyc(); st("val_macro0", 4'h4);
    cyc(); st("val_macro1", 4'h4);
    cyc(); st("val_macro2", 4'h4);
    macro_vencida = 1'b0;
    cyc(); st("val_macro3", 4'h4);
    cyc(); st("joga_micro", 4'h5);
  endtask

  task automatic micro_commit(input logic fj, input logic mv, input logic [1:0] expj);
    tem_jogada = 1'b1;
    cyc(); st("reg_micro", 4'h6);
    tem_jogada = 1'b0;
    repeat (4) begin cyc(); st("val_micro", 4'h7); end
    cyc(); st("reg_jogada", 4'h8);
    cyc(); st("ver_macro", 4'h9);
    cyc(); st("reg_result", 4'hA);
    fim_jogo = fj;
    cyc(); st("ver_tab", 4'hB);
    cyc();
    if (fj) begin
      st("fim", 4'hF);
      chk("jog_fim", 32'(jogador), 32'(expj));
      fim_jogo = 1'b0;
    end else begin
      st("trocar", 4'hC);
      macro_vencida = mv;
      cyc(); st("decide", 4'hD);
      chk("jog_turn", 32'(jogador), 32'(expj));
      cyc(); st("after_decide", mv ? 4'h1 : 4'h5);
      macro_vencida = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0;
    macro_vencida = 1'b0; micro_jogada = 1'b0; fim_jogo = 1'b0; exp_to = 1'b0;
    cyc(); cyc();
    st("reset", 4'h0);
    chk("jog_reset", 32'(jogador), 32'd0);
    reset = 1'b0;
    cyc(); st("idle", 4'h0);

    start_game();
    macro_phase();

    // Occupied micro cell goes back to joga_micro with no write; key presses in validation are ignored
    tem_jogada = 1'b1;
    cyc(); st("reg_micro_rej", 4'h6);
    micro_jogada = 1'b1;
    repeat (4) begin cyc(); st("val_micro_rej", 4'h7); end
    tem_jogada = 1'b0;
    cyc(); st("retry_micro", 4'h5);
    micro_jogada = 1'b0;

    micro_commit(1'b0, 1'b0, 2'd1);
    micro_commit(1'b0, 1'b0, 2'd2);
    micro_commit(1'b0, 1'b1, 2'd0);
    macro_phase();
    micro_commit(1'b0, 1'b0, 2'd1);
    micro_commit(1'b1, 1'b0, 2'd1);

    tem_jogada = 1'b1;
    cyc(); st("fim_hold", 4'hF);
    chk("jog_hold", 32'(jogador), 32'd1);
    tem_jogada = 1'b0;
    iniciar = 1'b1;
    cyc(); st("restart", 4'h0);
    iniciar = 1'b0;
    cyc(); st("restart_idle", 4'h0);
    chk("jog_restart", 32'(jogador), 32'd0);

    // Reset in the middle of valida_micro with a non-zero player
    start_game();
    macro_phase();
    micro_commit(1'b0, 1'b0, 2'd1);
    tem_jogada = 1'b1;
    cyc(); st("reg_micro_r", 4'h6);
    tem_jogada = 1'b0;
    cyc(); st("val_micro_r", 4'h7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    st("mid_reset", 4'h0);
    chk("jog_mid_reset", 32'(jogador), 32'd0);
    cyc(); st("post_reset", 4'h0);

`ifdef TURN_TIMEOUT_EN
    start_game();
    macro_phase();
    for (int i = 1; i < 10; i++) begin cyc(); st("wait_to", 4'h5); end
    exp_to = 1'b1;
    cyc(); st("timeout_trocar", 4'hC);
    chk("jog_to_c", 32'(jogador), 32'd0);
    exp_to = 1'b0;
    cyc(); st("timeout_decide", 4'hD);
    chk("jog_to_d", 32'(jogador), 32'd1);
    cyc(); st("timeout_next", 4'h5);
    for (int i = 1; i < 10; i++) begin cyc(); st("wait_key", 4'h5); end
    tem_jogada = 1'b1;
    cyc(); st("key_on_expiry", 4'h6);
    tem_jogada = 1'b0;
    cyc(); st("key_on_expiry_val", 4'h7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
